// File: rtl/dot_product_sequencer.sv
// Dot-product sequencer: pushes K unsigned operand pairs one at a time through an
// external sequential multiplier and presents the accumulated sum downstream.
module dot_product_sequencer #(
  parameter int N = 4,
  parameter int K = 4,
  localparam int ACC_W = 2*N + $clog2(K),
  localparam int CNT_W = ($clog2(K) < 1) ? 1 : $clog2(K)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_x,
  input  logic [N-1:0]     in_w,
  output logic             mul_start,
  input  logic             mul_ready,
  output logic [N-1:0]     mul_multiplicand,
  output logic [N-1:0]     mul_multiplier,
  input  logic [2*N-1:0]   mul_product,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    OUTPUT
  } state_t;

  state_t state, state_next;

  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [N-1:0]     op_x;
  logic [N-1:0]     op_w;

  logic accept;
  logic take_product;
  logic flush;
  logic last_pair;

  assign last_pair = (count == CNT_W'(K-1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // WAIT_BUSY exists so a stale ready from the previous product is never
  // mistaken for completion of the current one.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    take_product = 1'b0;
    flush        = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mul_ready) state_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (!mul_ready) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (mul_ready) begin
          take_product = 1'b1;
          state_next   = last_pair ? OUTPUT : IDLE;
        end
      end
      OUTPUT: begin
        if (out_ready) begin
          flush      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_x <= '0;
      op_w <= '0;
    end else if (accept) begin
      op_x <= in_x;
      op_w <= in_w;
    end
  end

  // count parks at K-1 while the result waits, so it never exceeds K-1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc   <= '0;
      count <= '0;
    end else if (take_product) begin
      acc <= acc + ACC_W'(mul_product);
      if (!last_pair) count <= count + CNT_W'(1);
    end else if (flush) begin
      acc   <= '0;
      count <= '0;
    end
  end

  assign in_ready         = (state == IDLE) && reset;
  assign mul_start        = (state == ISSUE);
  assign out_valid        = (state == OUTPUT);
  assign out_sum          = acc;
  assign mul_multiplicand = op_w;
  assign mul_multiplier   = op_x;

  count_in_range: assert property (@(posedge clock) disable iff (!reset)
    count <= CNT_W'(K-1));

  result_held: assert property (@(posedge clock) disable iff (!reset)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_sum)));

  operands_held: assert property (@(posedge clock) disable iff (!reset)
    (state != IDLE) |=> ($stable(op_x) && $stable(op_w)));

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer, with a behavioural sequential
// multiplier that shares the sequencer's reset.
module tb_dot_product_sequencer;
  localparam int N = 4;
  localparam int K = 4;
  localparam int ACC_W = 2*N + $clog2(K);

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_x = '0;
  logic [N-1:0]     in_w = '0;
  logic             mul_start;
  logic             mul_ready;
  logic [N-1:0]     mul_multiplicand;
  logic [N-1:0]     mul_multiplier;
  logic [2*N-1:0]   mul_product;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;

  int total = 0;
  int bad = 0;
  int cycle_no = 0;
  int out_cycles = 0;
  int stall_cycles = 0;
  int start_accepts = 0;
  int hs_times[$];
  logic [31:0] results[$];

  logic       mdl_ready;
  int         mdl_cnt;
  logic       sample_pend;
  logic [N-1:0] ma, mb;
  logic       mul_hold = 1'b0;
  logic       hold_arm = 1'b0;
  int         hold_left = 0;

  logic [N-1:0] vx[4];
  logic [N-1:0] vw[4];
  logic [31:0]  sum;

  dot_product_sequencer #(.N(N), .K(K)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_w(in_w),
    .mul_start(mul_start), .mul_ready(mul_ready),
    .mul_multiplicand(mul_multiplicand), .mul_multiplier(mul_multiplier),
    .mul_product(mul_product),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle_no++;

  // Multiplier: accepts start while ready, samples operands one cycle later,
  // raises ready again N+1 edges after accepting.
  assign mul_ready = mdl_ready && !mul_hold;
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      mdl_ready   <= 1'b1;
      mdl_cnt     <= 0;
      sample_pend <= 1'b0;
      ma          <= '0;
      mb          <= '0;
      mul_product <= '0;
    end else if (mul_start && mul_ready) begin
      mdl_ready   <= 1'b0;
      mdl_cnt     <= N + 1;
      sample_pend <= 1'b1;
    end else if (!mdl_ready) begin
      if (sample_pend) begin
        ma          <= mul_multiplicand;
        mb          <= mul_multiplier;
        sample_pend <= 1'b0;
      end
      mdl_cnt <= mdl_cnt - 1;
      if (mdl_cnt == 1) begin
        mdl_ready   <= 1'b1;
        mul_product <= (2*N)'(ma) * (2*N)'(mb);
      end
    end
  end

  always @(negedge clock) begin
    if (mul_hold) begin
      hold_left--;
      if (hold_left == 0) mul_hold = 1'b0;
    end else if (hold_arm && mul_start) begin
      mul_hold  = 1'b1;
      hold_left = 3;
      hold_arm  = 1'b0;
    end
  end

  always begin
    @(negedge clock);
    #1;
    if (reset) begin
      if (in_valid && in_ready) hs_times.push_back(cycle_no);
      if (out_valid) out_cycles++;
      if (out_valid && out_ready) results.push_back(32'(out_sum));
      if (mul_start && !mul_ready) stall_cycles++;
      if (mul_start && mul_ready) start_accepts++;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [N-1:0] x, input logic [N-1:0] w, input bit keep);
    int t = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_x = x;
    in_w = w;
    while (!in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) check_output("handshake_timeout", 0, 1);
    @(negedge clock);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic send_set(input bit keep);
    for (int i = 0; i < 4; i++) apply_stimulus(vx[i], vw[i], keep && (i < 3));
  endtask

  task automatic wait_result(output logic [31:0] s);
    int n0 = results.size();
    int t = 0;
    while (results.size() == n0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (results.size() == n0) begin
      check_output("result_timeout", 0, 1);
      s = '1;
    end else begin
      s = results[$];
    end
  endtask

  initial begin
    int oc0, rs0, t;

    #2;
    check_output("rst_in_ready", 32'(in_ready), 0);
    check_output("rst_out_valid", 32'(out_valid), 0);
    check_output("rst_mul_start", 32'(mul_start), 0);
    check_output("rst_out_sum", 32'(out_sum), 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    #1;
    check_output("first_in_ready", 32'(in_ready), 1);

    vx = '{3, 2, 15, 0}; vw = '{5, 7, 15, 9};
    oc0 = out_cycles;
    send_set(1'b0);
    wait_result(sum);
    check_output("sum_254", sum, 254);
    repeat (2) @(negedge clock);
    check_output("single_pulse", 32'(out_cycles - oc0), 1);

    vx = '{15, 15, 15, 15}; vw = '{15, 15, 15, 15};
    send_set(1'b0);
    wait_result(sum);
    check_output("sum_900", sum, 900);

    out_ready = 1'b0;
    vx = '{1, 3, 5, 7}; vw = '{2, 4, 6, 8};
    send_set(1'b0);
    t = 0;
    while (!out_valid && t < 300) begin
      @(negedge clock);
      t++;
    end
    check_output("hold_reached", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'(i % 2);
      in_x = 15;
      in_w = 15;
      check_output("hold_valid", 32'(out_valid), 1);
      check_output("hold_sum", 32'(out_sum), 100);
      check_output("hold_in_ready", 32'(in_ready), 0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check_output("accept_valid_low", 32'(out_valid), 0);
    check_output("acc_cleared", 32'(out_sum), 0);
    check_output("held_result", results[$], 100);
    vx = '{2, 2, 2, 2}; vw = '{3, 3, 3, 3};
    send_set(1'b0);
    wait_result(sum);
    check_output("sum_after_ignore", sum, 24);

    stall_cycles = 0;
    start_accepts = 0;
    hold_arm = 1'b1;
    vx = '{4, 6, 8, 10}; vw = '{5, 7, 9, 11};
    send_set(1'b0);
    wait_result(sum);
    check_output("stall_cycles", 32'(stall_cycles), 3);
    check_output("start_accepts", 32'(start_accepts), 4);
    check_output("sum_stalled", sum, 244);

    apply_stimulus(9, 9, 1'b0);
    apply_stimulus(9, 9, 1'b0);
    apply_stimulus(9, 9, 1'b0);
    repeat (2) @(negedge clock);
    oc0 = out_cycles;
    rs0 = results.size();
    reset = 1'b0;
    #1;
    check_output("abort_in_ready", 32'(in_ready), 0);
    check_output("abort_mul_start", 32'(mul_start), 0);
    check_output("abort_sum", 32'(out_sum), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (20) @(negedge clock);
    check_output("abort_no_valid", 32'(out_cycles - oc0), 0);
    check_output("abort_no_result", 32'(results.size() - rs0), 0);
    vx = '{1, 1, 1, 1}; vw = '{1, 1, 1, 1};
    send_set(1'b0);
    wait_result(sum);
    check_output("sum_after_abort", sum, 4);

    hs_times.delete();
    vx = '{2, 3, 4, 5}; vw = '{2, 3, 4, 5};
    send_set(1'b1);
    wait_result(sum);
    check_output("sum_b2b", sum, 54);
    check_output("b2b_count", 32'(hs_times.size()), 4);
    if (hs_times.size() == 4) begin
      for (int i = 1; i < 4; i++)
        check_output("b2b_gap", 32'(hs_times[i] - hs_times[i-1]), N + 4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/dot_product_sequencer.md
DOT_PRODUCT_SEQUENCER -- requirements
Module: dot_product_sequencer

Interface
REQ-001 Parameter N, default 4: operand width, equal to the multiplier's N.
REQ-002 Parameter K, default 4: operand pairs per dot product, K >= 2.
REQ-003 Derived ACC_W = 2*N + $clog2(K): accumulator width.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; the block is held in reset while reset=0.
REQ-006 in_valid  input  1  upstream operand pair valid.
REQ-007 in_ready  output  1  block accepts a pair this cycle.
REQ-008 in_x  input  N  activation operand, unsigned.
REQ-009 in_w  input  N  weight operand, unsigned.
REQ-010 mul_start  output  1  start request to the sequential multiplier.
REQ-011 mul_ready  input  1  multiplier ready/idle flag.
REQ-012 mul_multiplicand  output  N  carries the latched in_w.
REQ-013 mul_multiplier  output  N  carries the latched in_x.
REQ-014 mul_product  input  2N  multiplier result, already activated.
REQ-015 out_valid  output  1  dot-product result valid.
REQ-016 out_ready  input  1  downstream accepts the result.
REQ-017 out_sum  output  ACC_W  sum of K products.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, OUTPUT.
REQ-019 IDLE: in_ready=1; on in_valid=1, in_x and in_w SHALL be latched into operand registers and the next state SHALL be ISSUE.
REQ-020 Outside IDLE, in_ready SHALL be 0, and in_x/in_w SHALL be ignored.
REQ-021 ISSUE: mul_start=1. If mul_ready=1, the next state SHALL be WAIT_BUSY; otherwise the block SHALL stay in ISSUE with mul_start held at 1.
REQ-022 mul_start SHALL be 1 only in ISSUE, which gives a single-cycle start pulse when the multiplier is idle.
REQ-023 mul_multiplicand and mul_multiplier SHALL be driven from the operand registers and SHALL stay stable from ISSUE until leaving WAIT_DONE, because the multiplier samples them one cycle after accepting start.
REQ-024 WAIT_BUSY: when mul_ready=0, the next state SHALL be WAIT_DONE; otherwise the block SHALL stay in WAIT_BUSY.
REQ-025 WAIT_DONE: when mul_ready=1, the block SHALL set acc <= acc + zero-extended mul_product and count <= count + 1.
REQ-026 On that WAIT_DONE exit, the next state SHALL be OUTPUT if count was K-1, otherwise IDLE.
REQ-027 Per-pair latency with an idle multiplier SHALL be N+4 cycles from the in_valid/in_ready handshake to the accumulate edge (N+3 from ISSUE).
REQ-028 OUTPUT: out_valid=1 and out_sum=acc; both SHALL hold stable while out_ready=0.
REQ-029 In OUTPUT, when out_ready=1: acc <= 0, count <= 0, next state IDLE.
REQ-030 out_sum SHALL equal acc in every state; it is meaningful only while out_valid=1.
REQ-031 ACC_W SHALL hold K*(2^N-1)^2 without overflow; no saturation logic is required.
REQ-032 count SHALL be $clog2(K) bits (minimum 1) and SHALL never exceed K-1.

Reset
REQ-033 While reset=0: state=IDLE, acc=0, count=0, operand registers=0, mul_start=0, out_valid=0, in_ready=0.
REQ-034 After reset deasserts: in_ready=1 from the first cycle.
REQ-035 Reset asserted in any state, including mid-multiply, SHALL abort the dot product immediately; no partial sum is ever presented.
REQ-036 The multiplier's reset SHALL be driven from the same source so both blocks restart together.

Verification
REQ-037 N=4, K=4, pairs (3,5),(2,7),(15,15),(0,9), out_ready=1 -> a single out_valid pulse with out_sum=254.
REQ-038 All four pairs (15,15) -> out_sum=900, with no wrap in 10 bits.
REQ-039 After a result, hold out_ready=0 for 5 cycles -> out_valid=1 and out_sum constant throughout, in_ready=0; in_valid pulses are ignored; acc=0 after acceptance.
REQ-040 Force mul_ready=0 for 3 cycles on entry to ISSUE -> mul_start held high for 3 cycles, then one handshake; the result is still correct.
REQ-041 Assert reset during WAIT_DONE of the third pair -> out_valid stays 0. Then pairs (1,1) x4 -> out_sum=4.
REQ-042 Back-to-back in_valid=1 -> each pair accepted exactly N+4 cycles apart with an idle multiplier.
